// File: rtl/ksa_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor computing a - b - bin with a
// valid/ready stream on both sides, plus borrow-out and status flags.
module ksa_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int MSB    = WIDTH - 1;

  logic adv1, adv2, adv3;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
  logic             cin1_q, cin1_d, amsb1_q, amsb1_d, bmsb1_q, bmsb1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] gg2_q, gg2_d, p2_q, p2_d;
  logic             cin2_q, cin2_d, amsb2_q, amsb2_d, bmsb2_q, bmsb2_d;

  logic             v3_q, v3_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] gl [LEVELS+1];
  logic [WIDTH-1:0] pl [LEVELS];
  logic [WIDTH-1:0] carry_vec;

  // A stage may load whenever the stage after it is empty or moving on.
  always_comb begin
    adv3     = out_ready;
    adv2     = !v3_q || adv3;
    adv1     = !v2_q || adv2;
    in_ready = !v1_q || adv1;
  end

  always_comb begin
    v1_d    = v1_q;
    p1_d    = p1_q;
    g1_d    = g1_q;
    cin1_d  = cin1_q;
    amsb1_d = amsb1_q;
    bmsb1_d = bmsb1_q;
    if (in_ready) begin
      v1_d    = in_valid && in_ready;
      p1_d    = a ^ ~b;
      g1_d    = a & ~b;
      cin1_d  = ~bin;
      amsb1_d = a[MSB];
      bmsb1_d = b[MSB];
    end
  end

  // Carry-in is folded into bit 0 so every group generate is a true carry-out.
  always_comb begin
    for (int l = 0; l <= LEVELS; l++) gl[l] = '0;
    for (int l = 0; l < LEVELS; l++) pl[l] = '0;
    gl[0]    = g1_q;
    gl[0][0] = g1_q[0] | (p1_q[0] & cin1_q);
    pl[0]    = p1_q;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i - (1 << l)]);
          if (l < LEVELS - 1) pl[l+1][i] = pl[l][i] & pl[l][i - (1 << l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          if (l < LEVELS - 1) pl[l+1][i] = pl[l][i];
        end
      end
    end
  end

  always_comb begin
    v2_d    = v2_q;
    gg2_d   = gg2_q;
    p2_d    = p2_q;
    cin2_d  = cin2_q;
    amsb2_d = amsb2_q;
    bmsb2_d = bmsb2_q;
    if (adv1) begin
      v2_d    = v1_q;
      gg2_d   = gl[LEVELS];
      p2_d    = p1_q;
      cin2_d  = cin1_q;
      amsb2_d = amsb1_q;
      bmsb2_d = bmsb1_q;
    end
  end

  always_comb begin
    carry_vec = {gg2_q[WIDTH-2:0], cin2_q};
    v3_d      = v3_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    if (adv2) begin
      v3_d   = v2_q;
      diff_d = p2_q ^ carry_vec;
      bout_d = ~gg2_q[MSB];
      zero_d = ~|(p2_q ^ carry_vec);
      neg_d  = p2_q[MSB] ^ carry_vec[MSB];
      ovf_d  = (amsb2_q != bmsb2_q) && ((p2_q[MSB] ^ carry_vec[MSB]) != amsb2_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      p1_q    <= '0;
      g1_q    <= '0;
      cin1_q  <= 1'b0;
      amsb1_q <= 1'b0;
      bmsb1_q <= 1'b0;
      v2_q    <= 1'b0;
      gg2_q   <= '0;
      p2_q    <= '0;
      cin2_q  <= 1'b0;
      amsb2_q <= 1'b0;
      bmsb2_q <= 1'b0;
      v3_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      p1_q    <= p1_d;
      g1_q    <= g1_d;
      cin1_q  <= cin1_d;
      amsb1_q <= amsb1_d;
      bmsb1_q <= bmsb1_d;
      v2_q    <= v2_d;
      gg2_q   <= gg2_d;
      p2_q    <= p2_d;
      cin2_q  <= cin2_d;
      amsb2_q <= amsb2_d;
      bmsb2_q <= bmsb2_d;
      v3_q    <= v3_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Bench for ksa_sub_pipe: arithmetic reference model with an in-order queue,
// per-cycle result/in_ready comparison, and directed literal vectors.
module tb_ksa_sub_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout, zero, neg, ovf;

  typedef logic [W+3:0] res_t;

  int   errors   = 0;
  int   checks   = 0;
  int   consumed = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  res_t exp_q[$];

  ksa_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Result packed as {diff, bout, zero, neg, ovf}, from plain integer arithmetic.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    int u, s;
    logic [W-1:0] d;
    logic o;
    u = int'(ma) - int'(mb) - int'(mbin);
    s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    d = u[W-1:0];
    o = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
    return {d, (u < 0), (d == '0), d[W-1], o};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept/consume bookkeeping on the clock edge.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        consumed++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check_output("in_ready", {31'd0, in_ready}, {31'd0, !(exp_q.size() >= 3 && !out_ready)});
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got diff=%0h with out_valid=1, required no valid output", diff);
        end else begin
          check_output("result", {20'd0, diff, bout, zero, neg, ovf}, {20'd0, exp_q[0]});
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    int n;
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (!in_ready) begin
      check_output("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
    end
  endtask

  // Single beat into an empty pipe; checks latency and literal result.
  task automatic apply_stimulus(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic tbin, input res_t texp);
    int  cnt;
    logic seen;
    check_output({name, "_model"}, {20'd0, model(ta, tb, tbin)}, {20'd0, texp});
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check_output({name, "_latency"}, seen ? cnt : 0, 32'd3);
    check_output({name, "_dut"}, {20'd0, diff, bout, zero, neg, ovf}, {20'd0, texp});
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_output({name, "_drained"}, {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
  endtask

  initial begin
    int c0;
    #1;
    check_output("reset_outputs", {20'd0, out_valid, diff, bout, zero, neg}, 32'd0);
    check_output("reset_ovf_ready", {30'd0, ovf, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    apply_stimulus("basic",     8'h05, 8'h03, 1'b0, {8'h02, 4'b0000});
    apply_stimulus("underflow", 8'h00, 8'h01, 1'b0, {8'hFF, 4'b1010});
    apply_stimulus("borrow_in", 8'h10, 8'h0F, 1'b1, {8'h00, 4'b0100});
    apply_stimulus("ovf_pos",   8'h80, 8'h01, 1'b0, {8'h7F, 4'b0001});
    apply_stimulus("ovf_neg",   8'h7F, 8'hFF, 1'b0, {8'h80, 4'b1011});
    wait_drain("directed");

    // Backpressure: three beats fill the pipe, the fourth must wait.
    out_ready = 1'b0;
    drive_beat(8'h33, 8'h11, 1'b0);
    drive_beat(8'h20, 8'h30, 1'b0);
    drive_beat(8'h01, 8'h01, 1'b1);
    a = 8'h44; b = 8'h04; bin = 1'b0; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_output("full_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("hold_diff", {24'd0, diff}, 32'h22);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    c0 = consumed;
    drive_beat(8'h44, 8'h04, 1'b0);
    drive_beat(8'h00, 8'hFF, 1'b0);
    wait_drain("backpressure");
    check_output("bp_consumed", consumed - c0, 32'd5);

    // Throughput: back-to-back random beats with out_ready held high.
    max_run = 0;
    for (int i = 0; i < 16; i++) drive_beat(W'($urandom), W'($urandom), 1'($urandom));
    wait_drain("throughput");
    check_output("throughput_run", max_run, 32'd16);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive_beat(8'hAA, 8'h01, 1'b0);
    drive_beat(8'h55, 8'h05, 1'b0);
    @(posedge clk);
    #3;
    check_output("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    check_output("mid_reset_diff", {24'd0, diff}, 32'd0);
    check_output("mid_reset_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    apply_stimulus("post_reset", 8'h09, 8'h04, 1'b0, {8'h05, 4'b0000});
    wait_drain("post_reset");
    repeat (3) @(posedge clk);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ksa_sub_pipe.md
# ksa_sub_pipe

Pipelined, parameterized Kogge-Stone subtractor with a valid/ready stream interface on both sides. It computes `a - b - bin` using the same parallel-prefix carry network as the adder library, inverted for borrow, and reports borrow-out and status flags. It sits in the adders library beside the Kogge-Stone adder as its subtract-direction counterpart. It is intended for datapaths that need registered, back-pressurable difference and compare results.

## Interface
- `WIDTH`, default 8, operand and result width (≥ 2, power of two).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand beat present.
- `in_ready`  output  1  block accepts the operand beat this cycle.
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `bin`  input  1  borrow-in.
- `out_valid`  output  1  result beat present.
- `out_ready`  input  1  downstream accepts the result beat.
- `diff`  output  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1  unsigned borrow-out; 1 when `a < b + bin`.
- `zero`  output  1  `diff == 0`.
- `neg`  output  1  `diff[WIDTH-1]`.
- `ovf`  output  1  two's-complement signed overflow.

## Operation
- Arithmetic: `a + ~b + ~bin` in a WIDTH-bit Kogge-Stone prefix adder. Carry-in is `~bin`. `bout = ~cout`.
- Signed overflow: `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`.
- Three registered stages: S1, S2, S3. Each stage has a valid bit `v1`, `v2`, `v3`.
- S1 (precompute) registers:
  - per-bit `p = a ^ ~b` and `g = a & ~b`;
  - carry-in `~bin`;
  - `a[MSB]` and `b[MSB]`.
- S2 (prefix) registers the group generate for every bit position. All log2(WIDTH) Kogge-Stone levels are combinational between S1 and S2. The bit-0 generate folds in the carry-in.
- S3 (output) registers:
  - `diff = p ^ {carries[WIDTH-2:0], cin}`;
  - `bout`, `zero`, `neg`, `ovf`.
  - `out_valid = v3`.
- Flow control is bubble-collapsing:
  - `adv3 = out_ready`.
  - `adv2 = !v3 || adv3`.
  - `adv1 = !v2 || adv2`.
  - `in_ready = !v1 || adv1`.
- Stage k loads when its enable is high. Its valid bit takes the upstream valid. For S1 the upstream valid is `in_valid && in_ready`.
- An operand is accepted on a cycle when `in_valid && in_ready`. A result is consumed on a cycle when `out_valid && out_ready`.
- While `out_valid && !out_ready`, `diff`, `bout`, `zero`, `neg` and `ovf` hold stable. An upstream bubble can still be absorbed on a cycle where S3 is stalled.
- Data registers of invalid stages may load freely. Outputs are only meaningful when `out_valid` is high.
- No reordering, no dropping, no duplication. Results leave in acceptance order.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - `v1`, `v2`, `v3` = 0;
  - `out_valid` = 0;
  - `diff` = 0;
  - `bout`, `zero`, `neg`, `ovf` = 0.
- During reset `in_ready` = 1 (all stages empty). `in_ready` is combinational from `out_ready` and the valid bits.
- Latency: an operand accepted on cycle N appears with `out_valid = 1` after the rising edge ending cycle N+2. That is, the result is visible during cycle N+3 if no stall occurs.
- Throughput: one result per cycle with `out_ready` held high.
- Full pipeline with `out_ready = 0`: `in_ready = 0` after three accepted beats. No fourth beat is taken.
- Simultaneous consume and accept when full: both occur in the same cycle. There is no bubble.
- Reset mid-operation: all in-flight beats are discarded. `out_valid` drops immediately. The first post-reset result is from the first post-reset accepted beat.
- Wrap-around: `diff` is modulo 2^WIDTH. `bout` flags the unsigned underflow.

## Test plan
- Basic subtraction, WIDTH=8: `a=0x05, b=0x03, bin=0` -> `diff=0x02`, `bout=0`, `zero=0`, `neg=0`, `ovf=0`; `out_valid` rises exactly 3 cycles after acceptance.
- Underflow and borrow-in:
  - `a=0x00, b=0x01, bin=0` -> `diff=0xFF`, `bout=1`, `neg=1`, `ovf=0`.
  - `a=0x10, b=0x0F, bin=1` -> `diff=0x00`, `zero=1`, `bout=0`.
- Signed overflow:
  - `a=0x80, b=0x01` -> `diff=0x7F`, `ovf=1`, `bout=0`.
  - `a=0x7F, b=0xFF` -> `diff=0x80`, `ovf=1`, `bout=1`.
- Backpressure:
  - Hold `out_ready=0` and stream 5 beats. `in_ready` falls after 3 accepts, and the first result holds stable.
  - Release `out_ready`. All 5 results emerge in order, one per cycle, with no loss or duplication.
- Throughput: 16 back-to-back random operands with `out_ready=1`. 16 consecutive `out_valid` cycles, each matching the reference model `a - b - bin`.
- Reset mid-stream: assert `rst` asynchronously with 2 beats in flight. `out_valid` = 0 and `diff` = 0 immediately. After release, a new beat `0x09-0x04` yields `diff=0x05` with 3-cycle latency, and no stale results appear.
